// File: rtl/axi_common.sv
// axi_common: shared AXI response codes, burst type and response merge
package axi_common;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a == RESP_DECERR || b == RESP_DECERR) ? RESP_DECERR :
           (a == RESP_SLVERR || b == RESP_SLVERR) ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi_to_lite_bridge_if.sv
// axi_channel / axi_lite_channel: full AXI4 and AXI-lite bundles with master/slave views
interface axi_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 8
);
  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_qos;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic                    r_valid;
  logic                    r_ready;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_qos;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic                    w_valid;
  logic                    w_ready;
  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  modport master (
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready,
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready
  );
  modport slave (
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready,
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready
  );
endinterface

interface axi_lite_channel #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [2:0]              ar_prot;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [2:0]              aw_prot;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  modport master (
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready,
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready
  );
  modport slave (
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready,
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next beat address for FIXED/INCR, and WRAP when AXI_TO_LITE_WRAP_EN is defined
module axi_burst_addr_gen
  import axi_common::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  burst_t                burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  logic [ADDR_WIDTH-1:0] incr;
  assign incr = addr + (ADDR_WIDTH'(1) << size);
`ifdef AXI_TO_LITE_WRAP_EN
  logic [ADDR_WIDTH-1:0] mask;
  assign mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
  assign next_addr = burst == BURST_FIXED ? addr :
                     burst == BURST_WRAP  ? (addr & ~mask) | (incr & mask) : incr;
`else
  assign next_addr = burst == BURST_FIXED ? addr : incr;
`endif
endmodule

// File: rtl/axi_to_lite_bridge.sv
// axi_to_lite_bridge: splits AXI4 bursts into single AXI-lite beats; WRAP stepping via AXI_TO_LITE_WRAP_EN
module axi_to_lite_bridge
  import axi_common::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 8
) (
  input logic            clk,
  input logic            rstn,
  axi_channel.slave      master,
  axi_lite_channel.master slave
);
  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_BURST, WR_RESP} wr_state_t;
  rd_state_t             rd_state;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] rd_next;
  logic [7:0]            rd_len;
  logic [2:0]            rd_size;
  burst_t                rd_burst;
  logic [8:0]            rd_ar_cnt;
  logic [8:0]            rd_r_cnt;
  logic                  r_hs;
  wr_state_t             wr_state;
  logic [ID_WIDTH-1:0]   wr_id;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] wr_next;
  logic [7:0]            wr_len;
  logic [2:0]            wr_size;
  burst_t                wr_burst;
  logic [8:0]            wr_w_cnt;
  logic [8:0]            wr_b_cnt;
  logic [1:0]            wr_resp;
  logic                  wr_beat_ok;
  logic                  w_hs;
  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_addr (
    .addr(rd_addr), .len(rd_len), .size(rd_size), .burst(rd_burst), .next_addr(rd_next)
  );
  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_addr (
    .addr(wr_addr), .len(wr_len), .size(wr_size), .burst(wr_burst), .next_addr(wr_next)
  );
  assign r_hs             = slave.r_valid && master.r_ready;
  assign master.ar_ready  = rd_state == RD_IDLE;
  assign slave.ar_valid   = rd_state == RD_BURST && rd_ar_cnt <= {1'b0, rd_len};
  assign slave.ar_addr    = rd_addr;
  assign slave.ar_prot    = 3'b000;
  assign master.r_id      = rd_id;
  assign master.r_data    = slave.r_data;
  assign master.r_resp    = slave.r_resp;
  assign master.r_valid   = slave.r_valid;
  assign master.r_last    = rd_r_cnt == {1'b0, rd_len};
  assign slave.r_ready    = master.r_ready;
  // Read FSM: capture the burst, issue one lite AR per beat, finish on the last R
  always_ff @(posedge clk)
    if (!rstn) begin
      rd_state  <= RD_IDLE;
      rd_ar_cnt <= '0;
      rd_r_cnt  <= '0;
    end else if (rd_state == RD_IDLE) begin
      if (master.ar_valid) begin
        rd_id     <= master.ar_id;
        rd_addr   <= master.ar_addr;
        rd_len    <= master.ar_len;
        rd_size   <= master.ar_size;
        rd_burst  <= burst_t'(master.ar_burst);
        rd_ar_cnt <= '0;
        rd_r_cnt  <= '0;
        rd_state  <= RD_BURST;
      end
    end else begin
      if (slave.ar_valid && slave.ar_ready) begin
        rd_addr   <= rd_next;
        rd_ar_cnt <= rd_ar_cnt + 9'd1;
      end
      if (r_hs) begin
        rd_r_cnt <= rd_r_cnt + 9'd1;
        if (master.r_last) rd_state <= RD_IDLE;
      end
    end
  // The lite AW and W valids each wait on the other's ready so both handshakes land in the same cycle
  assign wr_beat_ok      = wr_state == WR_BURST && wr_w_cnt <= {1'b0, wr_len};
  assign master.w_ready  = wr_beat_ok && slave.aw_ready && slave.w_ready;
  assign w_hs            = master.w_valid && master.w_ready;
  assign slave.aw_valid  = wr_beat_ok && master.w_valid && slave.w_ready;
  assign slave.w_valid   = wr_beat_ok && master.w_valid && slave.aw_ready;
  assign slave.aw_addr   = wr_addr;
  assign slave.aw_prot   = 3'b000;
  assign slave.w_data    = master.w_data;
  assign slave.w_strb    = master.w_strb;
  assign slave.b_ready   = wr_state == WR_BURST;
  assign master.aw_ready = wr_state == WR_IDLE;
  assign master.b_valid  = wr_state == WR_RESP;
  assign master.b_id     = wr_id;
  assign master.b_resp   = wr_resp;
  // Write FSM: one lite AW+W per upstream beat, merge all lite B responses into one upstream B
  always_ff @(posedge clk)
    if (!rstn) begin
      wr_state <= WR_IDLE;
      wr_w_cnt <= '0;
      wr_b_cnt <= '0;
      wr_resp  <= RESP_OKAY;
    end else if (wr_state == WR_IDLE) begin
      if (master.aw_valid) begin
        wr_id    <= master.aw_id;
        wr_addr  <= master.aw_addr;
        wr_len   <= master.aw_len;
        wr_size  <= master.aw_size;
        wr_burst <= burst_t'(master.aw_burst);
        wr_w_cnt <= '0;
        wr_b_cnt <= '0;
        wr_resp  <= RESP_OKAY;
        wr_state <= WR_BURST;
      end
    end else if (wr_state == WR_BURST) begin
      if (w_hs) begin
        wr_addr  <= wr_next;
        wr_w_cnt <= wr_w_cnt + 9'd1;
      end
      if (slave.b_valid) begin
        wr_b_cnt <= wr_b_cnt + 9'd1;
        wr_resp  <= resp_merge(wr_resp, slave.b_resp);
        if (wr_b_cnt == {1'b0, wr_len}) wr_state <= WR_RESP;
      end
    end else if (master.b_ready) begin
      wr_state <= WR_IDLE;
    end
endmodule

// File: tb/tb_axi_to_lite_bridge.sv
// tb_axi_to_lite_bridge: randomized bench with lite slave model and burst address reference
module tb_axi_to_lite_bridge;
  import axi_common::*;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int IW = 8;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  axi_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) up();
  axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn();
  axi_to_lite_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rstn(rstn), .master(up), .slave(dn)
  );
  logic [63:0] ar_log[$];
  logic [63:0] aw_log[$];
  logic [63:0] wd_log[$];
  logic [7:0]  ws_log[$];
  logic [1:0]  plan[$];
  logic [63:0] rd_pend[$];
  logic [1:0]  b_pend[$];
  int b_sent = 0;
  bit flush = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Address of beat i from the burst rules: FIXED constant, INCR base + i*2^size, WRAP inside its window
  function automatic logic [63:0] exp_addr(input logic [63:0] a, input int len, input int size,
                                           input logic [1:0] burst, input int i);
    logic [63:0] step, win, base;
    step = 64'(i) << size;
    if (burst == 2'd0) return a;
`ifdef AXI_TO_LITE_WRAP_EN
    if (burst == 2'd2) begin
      win = 64'(len + 1) << size;
      base = a - (a % win);
      return base + ((a - base + step) % win);
    end
`endif
    return a + step;
  endfunction

  function automatic logic [63:0] rd_fn(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [1:0] rd_resp_fn(input logic [63:0] a);
    return a[5:3] == 3'd5 ? RESP_SLVERR : RESP_OKAY;
  endfunction

  // Lite slave model: random readies, in-order R and B replies, logs every accepted lite beat
  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [63:0] ara, awa, wd;
    logic [7:0] ws;
    ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
    ara = '0; awa = '0; wd = '0; ws = '0;
    dn.ar_ready = 0; dn.r_valid = 0; dn.r_data = '0; dn.r_resp = '0;
    dn.aw_ready = 0; dn.w_ready = 0; dn.b_valid = 0; dn.b_resp = '0;
    forever begin
      @(negedge clk);
      if (flush) begin
        rd_pend.delete();
        b_pend.delete();
        dn.r_valid = 0;
        dn.b_valid = 0;
        flush = 0;
      end else begin
        if (ar_hs) begin
          rd_pend.push_back(ara);
          ar_log.push_back(ara);
        end
        if (r_hs) begin
          dn.r_valid = 0;
          void'(rd_pend.pop_front());
        end
        if (!dn.r_valid && rd_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          dn.r_valid = 1;
          dn.r_data = rd_fn(rd_pend[0]);
          dn.r_resp = rd_resp_fn(rd_pend[0]);
        end
        if (aw_hs && w_hs) begin
          aw_log.push_back(awa);
          wd_log.push_back(wd);
          ws_log.push_back(ws);
          b_pend.push_back(plan.size() > 0 ? plan.pop_front() : RESP_OKAY);
        end
        if (b_hs) begin
          dn.b_valid = 0;
          b_sent++;
        end
        if (!dn.b_valid && b_pend.size() > 0 && $urandom_range(0, 1) == 1) begin
          dn.b_valid = 1;
          dn.b_resp = b_pend.pop_front();
        end
      end
      dn.ar_ready = 1'($urandom_range(0, 1));
      dn.aw_ready = 1'($urandom_range(0, 1));
      dn.w_ready = 1'($urandom_range(0, 1));
      #4;
      ar_hs = dn.ar_valid && dn.ar_ready;
      r_hs = dn.r_valid && dn.r_ready;
      aw_hs = dn.aw_valid && dn.aw_ready;
      w_hs = dn.w_valid && dn.w_ready;
      b_hs = dn.b_valid && dn.b_ready;
      ara = dn.ar_addr;
      awa = dn.aw_addr;
      wd = dn.w_data;
      ws = dn.w_strb;
      if (ar_hs) check("lite_ar_prot", 64'(dn.ar_prot), 0);
      if (aw_hs || w_hs) check("lite_aw_w_sync", 64'(aw_hs), 64'(w_hs));
      if (!rstn) flush = 1;
    end
  end

  task automatic do_read(input logic [IW-1:0] id, input logic [63:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    bit done;
    logic [63:0] ea, d;
    logic [1:0] rr;
    logic [IW-1:0] rid;
    logic rl;
    @(negedge clk);
    ar_log.delete();
    up.ar_valid = 1; up.ar_id = id; up.ar_addr = a; up.ar_len = len; up.ar_size = size;
    up.ar_burst = burst; up.ar_lock = 1'($urandom); up.ar_cache = 4'($urandom);
    up.ar_prot = 3'($urandom); up.ar_qos = 4'($urandom);
    n = 0; done = 0;
    while (!done && n < 200) begin
      #4; done = up.ar_ready;
      @(negedge clk); n++;
    end
    up.ar_valid = 0;
    if (!done) begin
      check("rd_ar_timeout", 0, 1);
      return;
    end
    for (int i = 0; i <= int'(len); i++) begin
      n = 0; done = 0; d = '0; rr = '0; rid = '0; rl = 0;
      while (!done && n < 200) begin
        up.r_ready = 1'($urandom_range(0, 1));
        #4;
        if (up.r_valid && up.r_ready) begin
          done = 1; d = up.r_data; rr = up.r_resp; rid = up.r_id; rl = up.r_last;
        end
        @(negedge clk); n++;
      end
      if (!done) begin
        up.r_ready = 0;
        check("rd_r_timeout", 0, 1);
        return;
      end
      ea = exp_addr(a, int'(len), int'(size), burst, i);
      check("rd_data", d, rd_fn(ea));
      check("rd_resp", 64'(rr), 64'(rd_resp_fn(ea)));
      check("rd_id", 64'(rid), 64'(id));
      check("rd_last", 64'(rl), 64'(i == int'(len)));
    end
    up.r_ready = 0;
    #4; check("rd_ar_ready_after", 64'(up.ar_ready), 1);
    @(negedge clk);
    check("rd_lite_count", 64'(ar_log.size()), 64'(int'(len) + 1));
    for (int i = 0; i <= int'(len) && i < ar_log.size(); i++)
      check("rd_lite_addr", ar_log[i], exp_addr(a, int'(len), int'(size), burst, i));
  endtask

  task automatic wr_aw(input logic [IW-1:0] id, input logic [63:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, output bit done);
    int n;
    up.aw_valid = 1; up.aw_id = id; up.aw_addr = a; up.aw_len = len; up.aw_size = size;
    up.aw_burst = burst; up.aw_lock = 1'($urandom); up.aw_cache = 4'($urandom);
    up.aw_prot = 3'($urandom); up.aw_qos = 4'($urandom);
    n = 0; done = 0;
    while (!done && n < 200) begin
      #4; done = up.aw_ready;
      @(negedge clk); n++;
    end
    up.aw_valid = 0;
    if (!done) check("wr_aw_timeout", 0, 1);
  endtask

  task automatic wr_beat(input logic [63:0] d, input logic [7:0] s, input bit last, output bit done);
    int n;
    up.w_valid = 1; up.w_data = d; up.w_strb = s; up.w_last = last;
    n = 0; done = 0;
    while (!done && n < 200) begin
      #4; done = up.w_ready;
      @(negedge clk); n++;
    end
    up.w_valid = 0;
    if (!done) check("wr_w_timeout", 0, 1);
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [63:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] ed[$];
    logic [7:0] es[$];
    logic [1:0] er, br;
    logic [IW-1:0] bid;
    logic [63:0] d;
    logic [7:0] s;
    int n, bs;
    bit ok;
    er = RESP_OKAY;
    foreach (plan[i]) begin
      if (plan[i] == RESP_DECERR) er = RESP_DECERR;
      else if (plan[i] == RESP_SLVERR && er != RESP_DECERR) er = RESP_SLVERR;
    end
    @(negedge clk);
    aw_log.delete(); wd_log.delete(); ws_log.delete(); b_sent = 0;
    wr_aw(id, a, len, size, burst, ok);
    if (!ok) return;
    for (int i = 0; i <= int'(len); i++) begin
      d = {$urandom, $urandom}; s = 8'($urandom);
      ed.push_back(d); es.push_back(s);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      wr_beat(d, s, i == int'(len), ok);
      if (!ok) return;
    end
    n = 0; ok = 0; br = '0; bid = '0; bs = 0;
    while (!ok && n < 400) begin
      up.b_ready = 1'($urandom_range(0, 1));
      #4;
      if (up.b_valid && up.b_ready) begin
        ok = 1; br = up.b_resp; bid = up.b_id; bs = b_sent;
      end
      @(negedge clk); n++;
    end
    up.b_ready = 0;
    plan.delete();
    if (!ok) begin
      check("wr_b_timeout", 0, 1);
      return;
    end
    check("wr_b_id", 64'(bid), 64'(id));
    check("wr_b_resp", 64'(br), 64'(er));
    check("wr_b_after_all_lite", 64'(bs), 64'(int'(len) + 1));
    #4; check("wr_b_single", 64'(up.b_valid), 0);
    @(negedge clk);
    check("wr_lite_count", 64'(aw_log.size()), 64'(int'(len) + 1));
    for (int i = 0; i <= int'(len) && i < aw_log.size(); i++) begin
      check("wr_lite_addr", aw_log[i], exp_addr(a, int'(len), int'(size), burst, i));
      check("wr_lite_data", wd_log[i], ed[i]);
      check("wr_lite_strb", 64'(ws_log[i]), 64'(es[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ar_ready"}, 64'(up.ar_ready), 1);
    check({tag, "_aw_ready"}, 64'(up.aw_ready), 1);
    check({tag, "_b_valid"}, 64'(up.b_valid), 0);
    check({tag, "_w_ready"}, 64'(up.w_ready), 0);
    check({tag, "_lite_ar_valid"}, 64'(dn.ar_valid), 0);
    check({tag, "_lite_aw_valid"}, 64'(dn.aw_valid), 0);
    check({tag, "_lite_w_valid"}, 64'(dn.w_valid), 0);
    check({tag, "_lite_b_ready"}, 64'(dn.b_ready), 0);
  endtask

  task automatic rand_burst(output logic [1:0] b, output logic [7:0] l, output logic [2:0] s,
                            output logic [63:0] a);
    b = 2'($urandom_range(0, 2));
    s = 3'($urandom_range(0, 3));
    l = b == 2'd2 ? 8'((2 << $urandom_range(0, 3)) - 1) : 8'($urandom_range(0, 15));
    a = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) a = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 64));
    if (b == 2'd2) a = a & ~((64'd1 << s) - 64'd1);
  endtask

  initial begin
    #900000;
    check("watchdog", 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] rb, wb;
    logic [7:0] rl, wl;
    logic [2:0] rs, ws;
    logic [63:0] ra, wa, d;
    bit ok;
    up.ar_valid = 0; up.ar_id = '0; up.ar_addr = '0; up.ar_len = '0; up.ar_size = '0; up.ar_burst = '0;
    up.ar_lock = 0; up.ar_cache = '0; up.ar_prot = '0; up.ar_qos = '0; up.r_ready = 0;
    up.aw_valid = 0; up.aw_id = '0; up.aw_addr = '0; up.aw_len = '0; up.aw_size = '0; up.aw_burst = '0;
    up.aw_lock = 0; up.aw_cache = '0; up.aw_prot = '0; up.aw_qos = '0;
    up.w_valid = 0; up.w_data = '0; up.w_strb = '0; up.w_last = 0; up.b_ready = 0;
    repeat (3) @(negedge clk);
    #4; check_idle_outputs("reset");
    @(negedge clk);
    rstn = 1;
    do_read(8'h5A, 64'h100, 8'd3, 3'd3, 2'd1);
    do_write(8'hA7, 64'h38, 8'd3, 3'd3, 2'd2);
    plan.push_back(RESP_OKAY); plan.push_back(RESP_SLVERR); plan.push_back(RESP_OKAY);
    do_write(8'h11, 64'h400, 8'd2, 3'd3, 2'd1);
    fork
      do_read(8'h21, 64'h1000, 8'd7, 3'd3, 2'd1);
      do_write(8'h22, 64'h2000, 8'd7, 3'd2, 2'd1);
    join
    @(negedge clk);
    aw_log.delete(); wd_log.delete(); ws_log.delete();
    wr_aw(8'h33, 64'h5000, 8'd3, 3'd3, 2'd1, ok);
    for (int i = 0; i < 2; i++) begin
      d = {$urandom, $urandom};
      wr_beat(d, 8'hFF, 1'b0, ok);
    end
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    #1; check_idle_outputs("abort");
    check("abort_lite_beats", 64'(aw_log.size()), 2);
    @(negedge clk);
    do_write(8'h34, 64'h6000, 8'd3, 3'd3, 2'd1);
    do_read(8'h44, 64'hFFF8, 8'd0, 3'd3, 2'd0);
    do_read(8'h55, 64'h8000, 8'd255, 3'd3, 2'd1);
    do_write(8'h66, 64'h9000, 8'd255, 3'd3, 2'd1);
    do_read(8'h77, 64'hFFFF_FFFF_FFFF_FFF0, 8'd3, 3'd2, 2'd1);
    for (int k = 0; k < 25; k++) begin
      rand_burst(rb, rl, rs, ra);
      rand_burst(wb, wl, ws, wa);
      for (int i = 0; i <= int'(wl); i++) begin
        int p;
        p = int'($urandom_range(0, 5));
        plan.push_back(p == 5 ? RESP_DECERR : p == 4 ? RESP_SLVERR : RESP_OKAY);
      end
      fork
        do_read(8'($urandom), ra, rl, rs, rb);
        do_write(8'($urandom), wa, wl, ws, wb);
      join
    end
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
